// File: rtl/float16_mul.sv
// float16_mul: IEEE 754 binary16 multiplier with one cycle of latency.
// The product is formed and rounded (nearest, ties to even) combinationally.
// Both result and out_valid come straight from registers.
module float16_mul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        out_valid
);

  // Leading-zero count of an 11-bit significand (11 when the input is zero).
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i <= 10; i++) begin
      if (v[i]) n = 4'(10 - i);
    end
    return n;
  endfunction

  // Operand fields and classification
  logic [4:0]  exp_a, exp_b;
  logic [9:0]  frac_a, frac_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic        sign;

  assign exp_a  = a[14:10];
  assign exp_b  = b[14:10];
  assign frac_a = a[9:0];
  assign frac_b = b[9:0];
  assign sign   = a[15] ^ b[15];

  assign a_nan  = (&exp_a) & (|frac_a);
  assign b_nan  = (&exp_b) & (|frac_b);
  assign a_inf  = (&exp_a) & ~(|frac_a);
  assign b_inf  = (&exp_b) & ~(|frac_b);
  assign a_zero = ~(|exp_a) & ~(|frac_a);
  assign b_zero = ~(|exp_b) & ~(|frac_b);

  // Significands with the hidden bit.  A subnormal gets its leading one
  // moved up to bit 10, and its exponent lowered to match, so that the
  // product below always lands in [2^20, 2^22).
  logic [10:0] sig_a_raw, sig_b_raw, sig_a, sig_b;
  logic [3:0]  lz_a, lz_b;
  logic signed [7:0] ea, eb;

  assign sig_a_raw = {|exp_a, frac_a};
  assign sig_b_raw = {|exp_b, frac_b};
  assign lz_a      = lzc11(sig_a_raw);
  assign lz_b      = lzc11(sig_b_raw);
  assign sig_a     = sig_a_raw << lz_a;
  assign sig_b     = sig_b_raw << lz_b;

  // Unbiased exponents.  A subnormal uses -14, as if its exponent field were 1.
  assign ea = $signed({3'b000, (exp_a == 5'd0) ? 5'd1 : exp_a}) - 8'sd15
              - $signed({4'b0000, lz_a});
  assign eb = $signed({3'b000, (exp_b == 5'd0) ? 5'd1 : exp_b}) - 8'sd15
              - $signed({4'b0000, lz_b});

  // Significand product and normalization to a leading one at bit 21
  logic [21:0]       prod, norm;
  logic signed [7:0] exp_sum;
  logic [7:0]        sh_amt;
  logic [43:0]       wide;
  logic [21:0]       w;
  logic [6:0]        exp_field;
  logic              guard, rnd, sticky, round_up;
  logic [16:0]       packed_res;
  logic              overflow;
  logic [15:0]       product;

  assign prod    = 22'(sig_a) * 22'(sig_b);
  assign norm    = prod[21] ? prod : {prod[20:0], 1'b0};
  // Biased result exponent before any subnormal adjustment
  assign exp_sum = ea + eb + 8'sd15 + $signed({7'b0000000, prod[21]});

  // Results below the normal range are shifted right into subnormal form.
  // The 22 extra low bits catch everything shifted out, for the sticky bit.
  assign sh_amt  = (exp_sum <= 8'sd0) ? 8'(8'sd1 - exp_sum) : 8'd0;
  assign wide    = {norm, 22'd0} >> sh_amt;
  assign w       = wide[43:22];

  // Bit 21 of w is set only when no denormalizing shift took place
  assign exp_field = w[21] ? exp_sum[6:0] : 7'd0;
  assign guard     = w[10];
  assign rnd       = w[9];
  assign sticky    = (|w[8:0]) | (|wide[21:0]);
  assign round_up  = guard & (rnd | sticky | w[11]);

  // A carry out of the fraction propagates into the exponent field.  This
  // also takes the largest subnormal up to the smallest normal.
  assign packed_res = {exp_field, w[20:11]} + 17'(round_up);
  assign overflow   = packed_res[16:10] >= 7'd31;

  // Special-case selection, highest priority first
  always_comb begin
    product = {sign, packed_res[14:0]};
    if (a_nan | b_nan)
      product = 16'h7E00;
    else if ((a_inf & b_zero) | (b_inf & a_zero))
      product = 16'h7E00;
    else if (a_inf | b_inf)
      product = {sign, 15'h7C00};
    else if (a_zero | b_zero)
      product = {sign, 15'h0000};
    else if (overflow)
      product = {sign, 15'h7C00};
  end

  // Output registers.  Result holds its value when no operand pair arrives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result    <= 16'h0000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) result <= product;
    end
  end

endmodule

// File: tb/tb_float16_mul.sv
// tb_float16_mul: random and directed checks of float16_mul against a
// reference model that works on real numbers.
module tb_float16_mul;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        out_valid;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  float16_mul dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else        for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  // Exact magnitude of a binary16 finite value
  function automatic real mag_of(input logic [15:0] h);
    int e, f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return $itor(f) * pow2(-24);
    return $itor(1024 + f) * pow2(e - 25);
  endfunction

  // Reference product: the exact real product, rounded to nearest-even
  // on the binary16 grid.
  function automatic logic [15:0] model_mul(input logic [15:0] x, input logic [15:0] y);
    logic        s;
    logic        xn, yn, xi, yi, xz, yz;
    real         p, quantum, q, rem, v;
    int          e, n, fr;
    logic [15:0] r;
    logic [4:0]  ef;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    xz = (x[14:0] == 0);
    yz = (y[14:0] == 0);
    s  = x[15] ^ y[15];
    if (xn || yn) return 16'h7E00;
    if ((xi && yz) || (yi && xz)) return 16'h7E00;
    if (xi || yi) return {s, 15'h7C00};
    if (xz || yz) return {s, 15'h0000};
    p = mag_of(x) * mag_of(y);
    if (p < pow2(-14)) quantum = pow2(-24);
    else begin
      e = -14;
      while (p >= pow2(e + 1)) e++;
      quantum = pow2(e - 10);
    end
    q   = p / quantum;
    n   = $rtoi(q);
    rem = q - $itor(n);
    if (rem > 0.5 || (rem == 0.5 && (n % 2) == 1)) n++;
    v = $itor(n) * quantum;
    if (v >= pow2(16)) return {s, 15'h7C00};
    if (v < pow2(-14)) begin
      r = 16'(n);
      r[15] = s;
      return r;
    end
    e = -14;
    while (v >= pow2(e + 1)) e++;
    fr = $rtoi(v / pow2(e - 10)) - 1024;
    ef = 5'(e + 15);
    return {s, ef, 10'(fr)};
  endfunction

  // Random operand with extra weight on zeros, subnormals, specials and tiny exponents
  function automatic logic [15:0] rand_op();
    int          k;
    logic [15:0] v;
    k = $urandom_range(0, 9);
    v = 16'($urandom);
    case (k)
      6: v[14:10] = 5'd0;
      7: begin v[14:10] = 5'h1F; if ($urandom_range(0, 1) == 0) v[9:0] = 10'd0; end
      8: v[14:0] = 15'd0;
      9: v[14:10] = 5'($urandom_range(1, 4));
      default: ;
    endcase
    return v;
  endfunction

  // Expected output registers derived from the model
  logic        m_valid;
  logic [15:0] m_result;

  // Track what the outputs must be after each clock edge
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_result <= 16'h0000;
    end else begin
      m_valid <= in_valid;
      if (in_valid) m_result <= model_mul(a, b);
    end
  end

  // Compare the DUT outputs against the model on every cycle
  always @(negedge clk) begin
    if (checking) begin
      tests++;
      if ({out_valid, result} !== {m_valid, m_result}) begin
        fails++;
        $display("FAIL cycle_check: got valid=%b result=%h, want valid=%b result=%h",
                 out_valid, result, m_valid, m_result);
      end
    end
  end

  task automatic check_out(input string name, input logic [15:0] want_r, input logic want_v);
    tests++;
    if (result !== want_r || out_valid !== want_v) begin
      fails++;
      $display("FAIL %s: got valid=%b result=%h, want valid=%b result=%h",
               name, out_valid, result, want_v, want_r);
    end else begin
      $display("[TB] %s: result=%h valid=%b", name, result, out_valid);
    end
  endtask

  localparam int NDIR = 13;
  logic [15:0] dir_a   [NDIR] = '{16'h3C00, 16'h4200, 16'h3C00, 16'hC000, 16'h3C01, 16'h0001,
                                  16'h7BFF, 16'h0400, 16'h0200, 16'h7C00, 16'h7E01, 16'hFC00,
                                  16'h8000};
  logic [15:0] dir_b   [NDIR] = '{16'h4000, 16'h4400, 16'h3C00, 16'h4000, 16'h3C01, 16'h3800,
                                  16'h7BFF, 16'h3800, 16'h4000, 16'h0000, 16'h3C00, 16'h4000,
                                  16'h3C00};
  logic [15:0] dir_exp [NDIR] = '{16'h4000, 16'h4A00, 16'h3C00, 16'hC400, 16'h3C02, 16'h0000,
                                  16'h7C00, 16'h0200, 16'h0400, 16'h7E00, 16'h7E00, 16'hFC00,
                                  16'h8000};

  initial begin
    logic [15:0] mres;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = 16'h0000;
    b        = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_state", 16'h0000, 1'b0);
    #1;
    rst_n    = 1'b1;
    checking = 1'b1;

    // Directed products on consecutive valid cycles; the model is pinned too
    for (int i = 0; i < NDIR; i++) begin
      a        = dir_a[i];
      b        = dir_b[i];
      in_valid = 1'b1;
      mres = model_mul(dir_a[i], dir_b[i]);
      tests++;
      if (mres !== dir_exp[i]) begin
        fails++;
        $display("FAIL model_pin_%0d: model=%h want=%h", i, mres, dir_exp[i]);
      end
      @(posedge clk);
      #1;
      check_out($sformatf("dir_%h_x_%h", dir_a[i], dir_b[i]), dir_exp[i], 1'b1);
    end

    // Idle cycles: result holds, out_valid drops
    in_valid = 1'b0;
    a        = 16'h4000;
    b        = 16'h4000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_out("idle_hold", 16'h8000, 1'b0);
    end

    // Reset dominates in_valid on the same edge
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 16'h4000;
    b        = 16'h4000;
    @(posedge clk);
    #1;
    check_out("reset_with_valid", 16'h0000, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("after_reset_release", 16'h4400, 1'b1);

    // Random stream with occasional idle cycles and rare resets
    for (int i = 0; i < 4000; i++) begin
      a        = rand_op();
      b        = rand_op();
      in_valid = ($urandom_range(0, 3) != 0);
      rst_n    = ($urandom_range(0, 199) != 0);
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
